// File: rtl/multi_channel_interval_timer.sv
// multi_channel_interval_timer
//   NUM_CH-channel interval timer behind one Avalon-MM slave. The channels share a
//   programmable 16-bit prescaler. Each channel has its own period, snapshot, control
//   and status registers, and each can run one-shot or continuous.
// Ports
//   clk, reset_n            clock and asynchronous active-low reset
//   address                 {global, chan, reg[1:0]}
//   chipselect, write_n     slave select and active-low write strobe
//   writedata / readdata    32-bit write data, registered read data (1 clk latency)
//   irq / irq_vec           OR of all channel interrupts / per-channel TO & ITO
module multi_channel_interval_timer #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 49999,
  parameter int unsigned ADDR_W       = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec
);

  localparam int unsigned PRE_W = 16;
  localparam int unsigned SEL_W = ADDR_W - 1;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(RESET_PERIOD);

  // Address decode
  logic             wr_en_c;
  logic             global_c;
  logic [1:0]       reg_c;
  logic [IDX_W-1:0] chan_c;
  logic             chan_ok_c;
  logic [NUM_CH-1:0] ch_wr_c;

  assign wr_en_c   = chipselect & ~write_n;
  assign global_c  = address[ADDR_W-1];
  assign reg_c     = address[1:0];
  assign chan_c    = IDX_W'(address[SEL_W-1:0] >> 2);
  assign chan_ok_c = 32'(chan_c) < NUM_CH;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wr_c[i] = wr_en_c && !global_c && chan_ok_c && (32'(chan_c) == 32'(i));
    end
  end

  // Shared prescaler: tick once every presc_q+1 clocks, restarted by PRESCALE/SYNC_START writes
  logic [PRE_W-1:0] presc_q;
  logic [PRE_W-1:0] pcnt_q;
  logic             presc_zero_c;
  logic             sync_c;
  logic             tick_c;

  assign presc_zero_c = wr_en_c && global_c && (reg_c == 2'd1 || reg_c == 2'd2);
  assign sync_c       = wr_en_c && global_c && (reg_c == 2'd2);
  assign tick_c       = !presc_zero_c && (pcnt_q == presc_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      if (wr_en_c && global_c && reg_c == 2'd1) presc_q <= writedata[PRE_W-1:0];
      if (presc_zero_c || pcnt_q == presc_q) pcnt_q <= '0;
      else                                   pcnt_q <= pcnt_q + PRE_W'(1);
    end
  end

  // Per-channel state, exported as packed vectors for the read mux
  logic [NUM_CH-1:0]            run_q;
  logic [NUM_CH-1:0]            to_q;
  logic [NUM_CH-1:0]            irq_next_c;
  logic [NUM_CH-1:0][3:0]       ctrl_q;
  logic [NUM_CH-1:0][CNT_W-1:0] period_q;
  logic [NUM_CH-1:0][CNT_W-1:0] snap_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] period_r;
    logic [CNT_W-1:0] snap_r;
    logic [3:0]       ctrl_r;
    logic             run_r;
    logic             to_r;
    logic             reload_r;   // PERIOD written last clk: force reload and stop
    logic wr_status_c, wr_ctrl_c, wr_period_c, wr_snap_c;
    logic start_c, stop_c, timeout_c;

    assign wr_status_c = ch_wr_c[i] && reg_c == 2'd0;
    assign wr_ctrl_c   = ch_wr_c[i] && reg_c == 2'd1;
    assign wr_period_c = ch_wr_c[i] && reg_c == 2'd2;
    assign wr_snap_c   = ch_wr_c[i] && reg_c == 2'd3;
    assign start_c     = (wr_ctrl_c && writedata[2]) || (sync_c && writedata[i]);
    assign stop_c      = wr_ctrl_c && writedata[3];
    assign timeout_c   = !reload_r && run_r && tick_c && (count_r == '0);

    // Interrupt from next-state values so irq moves on the same clk as TO/ITO
    assign irq_next_c[i] = (timeout_c || (to_r && !wr_status_c)) &&
                           (wr_ctrl_c ? writedata[0] : ctrl_r[0]);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count_r  <= RESET_CNT;
        period_r <= RESET_CNT;
        snap_r   <= '0;
        ctrl_r   <= '0;
        run_r    <= 1'b0;
        to_r     <= 1'b0;
        reload_r <= 1'b0;
      end else begin
        if (reload_r)                count_r <= period_r;
        else if (run_r && tick_c)    count_r <= (count_r == '0) ? period_r
                                                                : count_r - CNT_W'(1);

        // Reload beats START; START beats STOP; explicit commands beat the timeout's CONT
        if (reload_r)       run_r <= 1'b0;
        else if (start_c)   run_r <= 1'b1;
        else if (stop_c)    run_r <= 1'b0;
        else if (timeout_c) run_r <= ctrl_r[1];

        // A timeout on the clear clk wins so the event is not lost
        if (timeout_c)        to_r <= 1'b1;
        else if (wr_status_c) to_r <= 1'b0;

        if (wr_ctrl_c)   ctrl_r   <= writedata[3:0];
        if (wr_period_c) period_r <= writedata[CNT_W-1:0];
        if (wr_snap_c)   snap_r   <= count_r;
        reload_r <= wr_period_c;
      end
    end

    assign run_q[i]    = run_r;
    assign to_q[i]     = to_r;
    assign ctrl_q[i]   = ctrl_r;
    assign period_q[i] = period_r;
    assign snap_q[i]   = snap_r;
  end

  // Read mux, sampled every clk regardless of chipselect
  logic [31:0] rd_c;

  always_comb begin
    rd_c = '0;
    if (global_c) begin
      case (reg_c)
        2'd0:    rd_c = 32'(irq_vec);
        2'd1:    rd_c = 32'(presc_q);
        default: rd_c = '0;
      endcase
    end else if (chan_ok_c) begin
      case (reg_c)
        2'd0:    rd_c = 32'({run_q[chan_c], to_q[chan_c]});
        2'd1:    rd_c = 32'(ctrl_q[chan_c]);
        2'd2:    rd_c = 32'(period_q[chan_c]);
        default: rd_c = 32'(snap_q[chan_c]);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq_vec  <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= rd_c;
      irq_vec  <= irq_next_c;
      irq      <= |irq_next_c;
    end
  end

endmodule
